// File: rtl/crc16_pkg.sv
// Shared CRC-16 definitions (x^16+x^15+x^2+1, MSB first) used by the serial
// encoder and the serial checker.
package crc16_pkg;

  localparam int unsigned CRC_W      = 16;
  localparam int unsigned CHECK_BITS = 16;

  localparam logic [CRC_W-1:0] POLY = 16'h8005;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/crc16_lfsr_step.sv
// One-bit combinational advance of the CRC-16 LFSR (Galois form, MSB first).
module crc16_lfsr_step
  import crc16_pkg::*;
(
  input  logic [CRC_W-1:0] crc,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_next
);

  logic fb;

  // Feedback taps come straight from POLY: bits 0, 2 and 15 for 16'h8005.
  always_comb begin
    fb       = crc[CRC_W-1] ^ bit_in;
    crc_next = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/crc16_serial_checker.sv
// Serial CRC-16 receive checker: forwards data bits, counts them, and flags a
// zero remainder after the 16 check bits. Define CRC16_CHK_ERRCNT_EN for err_cnt.
module crc16_serial_checker
  import crc16_pkg::*;
#(
  parameter int unsigned       LEN_W = 16,
  parameter logic [CRC_W-1:0]  INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             d_finish,
  output logic             data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic [LEN_W-1:0] len_out
`ifdef CRC16_CHK_ERRCNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam logic [4:0] LAST_CHK = 5'(CHECK_BITS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CRC_W-1:0] lfsr;
  logic [CRC_W-1:0] lfsr_nxt;
  logic [LEN_W-1:0] len;
  logic [4:0]       chk_cnt;
  logic             take_data;
  logic             take_check;
  logic             finish;

  crc16_lfsr_step u_step (
    .crc      (lfsr),
    .bit_in   (bit_in),
    .crc_next (lfsr_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // load wins over any bit presented in the same cycle: the frame restarts
  // and that bit is dropped. In DONE the verdict cycle still completes.
  always_comb begin
    state_nxt  = state;
    take_data  = 1'b0;
    take_check = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (load) state_nxt = DATA;
      end
      DATA: begin
        if (load) begin
          state_nxt = DATA;
        end else if (bit_valid) begin
          take_data = 1'b1;
          if (d_finish) state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (load) begin
          state_nxt = DATA;
        end else if (bit_valid) begin
          take_check = 1'b1;
          if (chk_cnt == LAST_CHK) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = load ? DATA : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == DATA) || (state == CHECK);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr       <= INIT;
      len        <= '0;
      chk_cnt    <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      crc_ok     <= 1'b0;
      len_out    <= '0;
    end else begin
      data_valid <= take_data;
      if (take_data) data_out <= bit_in;

      if (load) begin
        lfsr    <= INIT;
        len     <= '0;
        chk_cnt <= '0;
        crc_ok  <= 1'b0;
        len_out <= '0;
      end else begin
        if (take_data || take_check) lfsr <= lfsr_nxt;
        else if (state == DONE)      lfsr <= INIT;

        if (take_data && (len != '1)) len <= len + LEN_W'(1);

        if (take_check) chk_cnt <= finish ? '0 : chk_cnt + 5'd1;

        // Verdict uses the post-shift LFSR so it is visible together with done.
        if (finish) begin
          crc_ok  <= (lfsr_nxt == '0);
          len_out <= len;
        end
      end
    end
  end

`ifdef CRC16_CHK_ERRCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (!load && finish && (lfsr_nxt != '0) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc16_serial_checker.sv
// Self-checking bench for crc16_serial_checker: directed vector table, corner
// sequences, and random frames checked against a long-division CRC model.
module tb_crc16_serial_checker;

  typedef bit bitq_t[$];

  typedef struct {
    logic [31:0] data;
    int unsigned len;
    logic [15:0] chk;
    int unsigned max_gap;
    bit          ok;
    int unsigned exp_len;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        d_finish = 1'b0;
  logic        data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic [15:0] len_out;
`ifdef CRC16_CHK_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  crc16_serial_checker #(
    .LEN_W (16),
    .INIT  (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .d_finish   (d_finish),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done),
    .crc_ok     (crc_ok),
    .len_out    (len_out)
`ifdef CRC16_CHK_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned exp_err  = 0;

  bit          got_bits[$];
  bit          got_ok[$];
  logic [15:0] got_len[$];
  bit          exp_bits[$];
  bit          exp_ok[$];
  logic [15:0] exp_len[$];

  always @(posedge clk) begin
    #1;
    if (data_valid) got_bits.push_back(data_out);
    if (done) begin
      got_ok.push_back(crc_ok);
      got_len.push_back(len_out);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic cyc(input logic l, input logic v, input logic b, input logic f);
    @(negedge clk);
    load      = l;
    bit_valid = v;
    bit_in    = b;
    d_finish  = f;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic bitq_t to_bits(input logic [31:0] d, input int unsigned n);
    bitq_t q;
    for (int unsigned i = 0; i < n; i++) q.push_back(d[n-1-i]);
    return q;
  endfunction

  // Reference: remainder of (message * x^16) divided by 0x18005, by long division.
  function automatic logic [15:0] ref_crc(input bitq_t msg);
    bitq_t       m;
    logic [16:0] divisor;
    logic [15:0] r;
    divisor = 17'h18005;
    m = msg;
    repeat (16) m.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (m[i])
        for (int j = 0; j < 17; j++) m[i+j] = m[i+j] ^ divisor[16-j];
    for (int k = 0; k < 16; k++) r[15-k] = m[msg.size()+k];
    return r;
  endfunction

  task automatic send(input bitq_t bits, input logic [15:0] chk,
                      input int unsigned max_gap, input bit do_load);
    if (do_load) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < bits.size(); i++) begin
      idle($urandom_range(max_gap, 0));
      cyc(1'b0, 1'b1, bits[i], (i == bits.size() - 1));
    end
    for (int k = 0; k < 16; k++) begin
      idle($urandom_range(max_gap, 0));
      cyc(1'b0, 1'b1, chk[15-k], 1'b0);
    end
  endtask

  task automatic expect_frame(input bitq_t bits, input bit ok, input int unsigned n);
    foreach (bits[i]) exp_bits.push_back(bits[i]);
    exp_ok.push_back(ok);
    exp_len.push_back(16'(n));
    if (!ok) exp_err++;
  endtask

  task automatic verify(input string tag);
    int unsigned bad;
    check({tag, "_done_count"}, got_ok.size(), exp_ok.size());
    for (int i = 0; i < got_ok.size() && i < exp_ok.size(); i++) begin
      check({tag, "_crc_ok"}, got_ok[i], exp_ok[i]);
      check({tag, "_len_out"}, got_len[i], exp_len[i]);
    end
    check({tag, "_data_count"}, got_bits.size(), exp_bits.size());
    bad = 0;
    for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++)
      if (got_bits[i] != exp_bits[i]) bad++;
    check({tag, "_data_bad_bits"}, bad, 0);
`ifdef CRC16_CHK_ERRCNT_EN
    check({tag, "_err_cnt"}, err_cnt, exp_err);
`endif
    got_bits.delete(); got_ok.delete(); got_len.delete();
    exp_bits.delete(); exp_ok.delete(); exp_len.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outputs"}, {data_out, data_valid, busy, done, crc_ok, len_out}, '0);
`ifdef CRC16_CHK_ERRCNT_EN
    check({tag, "_err_cnt"}, err_cnt, 0);
`endif
  endtask

  initial begin
    vec_t        vecs[6];
    bitq_t       b01;
    bitq_t       b02;
    bitq_t       bits;
    logic [15:0] flip;
    logic [15:0] chk;

    vecs[0] = '{32'h01,   8,  16'h8005, 0, 1'b1, 8};
    vecs[1] = '{32'h02,   8,  16'h800F, 3, 1'b1, 8};
    vecs[2] = '{32'h01,   8,  16'h8004, 0, 1'b0, 8};
    vecs[3] = '{32'h1,    1,  16'h8005, 0, 1'b1, 1};
    vecs[4] = '{32'h0000, 16, 16'h0000, 1, 1'b1, 16};
    vecs[5] = '{32'h02,   8,  16'h8005, 2, 1'b0, 8};
    b01 = to_bits(32'h01, 8);
    b02 = to_bits(32'h02, 8);

    idle(2);
    check_all_zero("reset");
    @(negedge clk) rst = 1'b1;
    idle(2);

    foreach (vecs[v]) begin
      bits = to_bits(vecs[v].data, vecs[v].len);
      send(bits, vecs[v].chk, vecs[v].max_gap, 1'b1);
      expect_frame(bits, vecs[v].ok, vecs[v].exp_len);
      idle(4);
      verify($sformatf("vec%0d", v));
    end

    // busy rises after load, falls as done pulses
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk) #1;
    check("busy_after_load", busy, 1'b1);
    send(b01, 16'h8005, 0, 1'b0);
    @(posedge clk) #1;
    check("done_pulse", done, 1'b1);
    check("busy_in_done", busy, 1'b0);
    expect_frame(b01, 1'b1, 8);
    idle(3);
    verify("busy_seq");

    // load during the 5th check bit aborts, then a clean frame follows
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    foreach (b01[i]) cyc(1'b0, 1'b1, b01[i], (i == 7));
    foreach (b01[i]) exp_bits.push_back(b01[i]);
    chk = 16'h8005;
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, chk[15-k], 1'b0);
    cyc(1'b1, 1'b1, chk[11], 1'b0);
    send(b01, 16'h8005, 0, 1'b0);
    expect_frame(b01, 1'b1, 8);
    idle(4);
    verify("abort");

    // reset for one cycle in mid-DATA
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, b02[i], 1'b0);
    @(negedge clk);
    load = 1'b0; bit_valid = 1'b0; d_finish = 1'b0; rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk) rst = 1'b1;
    check("mid_reset_no_done", got_ok.size(), 0);
    got_bits.delete(); got_ok.delete(); got_len.delete();
    exp_err = 0;
    idle(1);
    send(b02, 16'h800F, 1, 1'b1);
    expect_frame(b02, 1'b1, 8);
    idle(4);
    verify("after_reset");

    // back-to-back: second load lands in the DONE cycle
    send(b01, 16'h8005, 0, 1'b1);
    send(b02, 16'h800F, 0, 1'b1);
    expect_frame(b01, 1'b1, 8);
    expect_frame(b02, 1'b1, 8);
    idle(4);
    verify("b2b");

    // random frames, some back-to-back, some with corrupted check bits
    for (int f = 0; f < 16; f++) begin
      bits.delete();
      repeat ($urandom_range(24, 1)) bits.push_back(1'($urandom_range(1, 0)));
      flip = '0;
      if ($urandom_range(1, 0) == 1) flip[$urandom_range(15, 0)] = 1'b1;
      send(bits, ref_crc(bits) ^ flip, $urandom_range(2, 0), 1'b1);
      expect_frame(bits, (flip == '0), bits.size());
      if ($urandom_range(1, 0) == 1) idle(2);
    end
    idle(4);
    verify("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/crc16_serial_checker.md
# crc16_serial_checker

Serial CRC-16 receive-side checker that sits directly downstream of the serial CRC-16 encoder. It consumes the encoded bitstream, MSB first: data bits followed by the 16 appended check bits. It forwards the data bits, counts them, and reports whether the frame's remainder is zero. Polynomial x^16+x^15+x^2+1, init 0, no reflection, no final XOR, matching the encoder bit-for-bit.

## Interface
- LEN_W, 16: width of the data-length counter and `len_out`.
- INIT, 16'h0000: LFSR value loaded on frame start.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  frame start pulse; sampled every cycle.
- bit_valid  in  1  qualifies `bit_in` (and `d_finish`).
- bit_in  in  1  serial codeword bit, MSB first.
- d_finish  in  1  with `bit_valid`, marks the last data bit.
- data_out  out  1  forwarded data bit.
- data_valid  out  1  qualifies `data_out`.
- busy  out  1  high in DATA or CHECK.
- done  out  1  one-cycle pulse when the verdict is valid.
- crc_ok  out  1  1 = remainder zero; held until the next `load`.
- len_out  out  LEN_W  data bits in the last frame; held until the next `load`.

## Operation
- States: IDLE, DATA, CHECK, DONE.
- IDLE: LFSR = INIT.
  - `load` -> DATA; also clears the length count and `crc_ok`.
- DATA: each `bit_valid` cycle shifts `bit_in` into the LFSR.
  - fb = reg[15]^bit_in.
  - reg[0] <= fb; reg[1] <= reg[0]; reg[2] <= reg[1]^fb.
  - reg[14:3] <= reg[13:2]; reg[15] <= reg[14]^fb.
  - Each valid bit: `data_out` <= `bit_in`, `data_valid` <= 1, length +1 (saturates at 2^LEN_W-1).
  - `bit_valid` & `d_finish` -> CHECK after that bit is processed.
  - `d_finish` without `bit_valid` is ignored.
- CHECK: the next 16 valid bits shift through the same LFSR.
  - Check bits are not forwarded; `data_valid` stays 0.
  - A 5-bit counter counts 0..15; the 16th valid bit -> DONE.
- DONE: one cycle, then IDLE.
  - `done` = 1.
  - `crc_ok` = (LFSR == 0).
  - `len_out` = length.
- `bit_valid` gaps are legal in DATA and CHECK; state and LFSR hold.
- `load` in DATA or CHECK aborts the frame and restarts: LFSR = INIT, counters cleared, state DATA, no `done`.
- `load` in DONE: DONE completes normally, then the restart applies in the same cycle, going directly to DATA.
- Bits in IDLE are ignored.
- Minimum frame: 1 data bit + 16 check bits.

## Timing
- Reset: state IDLE, LFSR = INIT, counters 0, and every output 0 (`data_out`, `data_valid`, `busy`, `done`, `crc_ok`, `len_out`, `err_cnt`).
- `data_out`/`data_valid`: 1-cycle latency from the accepted bit.
- `busy` rises the cycle after `load` and falls on entry to DONE.
- `done` asserts the cycle after the 16th check bit is accepted.
- `crc_ok` and `len_out` update in that same cycle.
- Reset mid-frame: immediate return to reset values; no `done`.

## Configuration
- CRC16_CHK_ERRCNT_EN defined:
  - Adds output `err_cnt` (16 bits).
  - Increments on each `done` with `crc_ok` = 0; saturates at 16'hFFFF.
  - Cleared only by `rst`.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `crc16_pkg`:
  - State enum (IDLE/DATA/CHECK/DONE).
  - POLY constant 16'h8005.
  - CRC width 16 and check-bit count 16.
  - This package is also used by the encoder.
- One sub-module, `crc16_lfsr_step`: combinational next-state for one bit, given reg and bit_in. Instantiated here; reusable by the encoder.

## Test plan
- Frame 8'h01 + check 16'h8005:
  - `data_out` stream 0,0,0,0,0,0,0,1.
  - `done` pulse; `crc_ok` = 1; `len_out` = 8.
- Frame 8'h02 + 16'h800F, with random `bit_valid` gaps of 0–3 cycles -> `crc_ok` = 1, `len_out` = 8.
- Frame 8'h01 + 16'h8004 (last check bit flipped) -> `crc_ok` = 0. With the macro: `err_cnt` = 1; a second bad frame gives 2.
- `load` during the 5th check bit, then a clean 8'h01 + 8005 frame -> exactly one `done`, `crc_ok` = 1, `len_out` = 8.
- `rst` low for one cycle in mid-DATA -> all outputs 0 immediately, IDLE; a following clean frame passes.
- Back-to-back: `load` asserted in the DONE cycle, followed by the next frame -> both frames report correctly with no lost bits.
